// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and price-table helper for the vending controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_t;

    localparam int unsigned c_price_w_max     = 32;
    localparam int unsigned c_price_tbl_max_w = 1024;

    // Product 0 occupies the least-significant byte.
    localparam logic [31:0] c_default_price_table = {8'd5, 8'd20, 8'd15, 8'd10};

    // Extracts the w-bit field number idx from a packed price table.
    function automatic logic [c_price_w_max-1:0] price_lookup(
        input logic [c_price_tbl_max_w-1:0] tbl,
        input int unsigned                  idx,
        input int unsigned                  w
    );
        logic [c_price_tbl_max_w-1:0] shifted;
        logic [c_price_w_max-1:0]     mask;
        shifted = tbl >> (idx * w);
        mask    = '1;
        mask    = mask >> (c_price_w_max - w);
        return shifted[c_price_w_max-1:0] & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_out.sv
`default_nettype none
// ============================================================================
// Module      : vend_change_out
// Description : Holds the value still owed and hands it out in CHANGE_UNIT
//               chunks over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_change_out #(
    parameter int CREDIT_W    = 8,
    parameter int CHANGE_UNIT = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                change_ready,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                last
);

    localparam logic [CREDIT_W-1:0] c_unit = CREDIT_W'(CHANGE_UNIT);

    logic [CREDIT_W-1:0] r_remaining;
    logic [CREDIT_W-1:0] r_amt;
    logic                r_valid;
    logic                w_fire;
    logic [CREDIT_W-1:0] w_rem_nxt;

    assign w_fire    = r_valid && change_ready;
    assign w_rem_nxt = load ? load_val : (r_remaining - r_amt);
    assign last      = w_fire && (r_remaining == r_amt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_amt       <= '0;
            r_valid     <= 1'b0;
        end else if (load || w_fire) begin
            r_remaining <= w_rem_nxt;
            r_amt       <= (w_rem_nxt < c_unit) ? w_rem_nxt : c_unit;
            r_valid     <= (w_rem_nxt != '0);
        end
    end

    assign change_valid = r_valid;
    assign change_amt   = r_amt;

endmodule
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl_multi
// Description : Multi-product coin vending controller: credit accumulation,
//               priced selection, one-hot dispense pulse, chunked change.
//               Optional idle auto-refund enabled by macro VEND_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                            CREDIT_W    = 8,
    parameter int                            COIN_W      = 4,
    parameter int                            NUM_PROD    = 4,
    parameter logic [NUM_PROD*CREDIT_W-1:0]  PRICE_TABLE = c_default_price_table,
    parameter int                            CHANGE_UNIT = 5,
    parameter int                            TIMEOUT_CYC = 1000,
    localparam int                           SEL_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_nack,
    output logic [NUM_PROD-1:0] dispencer,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                LED_Green,
    output logic                LED_Yellow
);

    localparam logic [c_price_tbl_max_w-1:0] c_price_tbl = c_price_tbl_max_w'(PRICE_TABLE);
    localparam int                           c_sum_w     = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
    localparam logic [c_sum_w-1:0]           c_credit_max = c_sum_w'({CREDIT_W{1'b1}});

    vend_state_t         r_state;
    vend_state_t         w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                r_coin_reject;
    logic                w_coin_reject_nxt;
    logic                r_sel_nack;
    logic                w_sel_nack_nxt;
    logic [NUM_PROD-1:0] r_dispense;
    logic [NUM_PROD-1:0] w_dispense_nxt;
    logic                r_led_green;
    logic                r_led_yellow;

    logic                w_ready_state;
    logic                w_coin_nz;
    logic [c_sum_w-1:0]  w_sum;
    logic                w_sum_ok;
    logic [CREDIT_W-1:0] w_price;
    logic                w_sel_ok;
    logic                w_cancel_acc;
    logic                w_sel_acc;
    logic                w_coin_acc;
    logic                w_timeout;
    logic                w_chg_load;
    logic                w_chg_fire;
    logic                w_chg_last;
    logic                w_chg_valid;
    logic [CREDIT_W-1:0] w_chg_amt;
    logic                w_green_nxt;

    assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
    assign w_coin_nz     = (coin != '0);
    assign w_sum         = c_sum_w'(r_credit) + c_sum_w'(coin);
    assign w_sum_ok      = (w_sum <= c_credit_max);
    assign w_price       = CREDIT_W'(price_lookup(c_price_tbl, 32'(sel_id), CREDIT_W));
    assign w_sel_ok      = (32'(sel_id) < 32'(NUM_PROD)) && (r_credit >= w_price);

    // Priority cancel > select > coin; a losing coin or select is refused.
    assign w_cancel_acc  = (r_state == ST_CREDIT) && (cancel || w_timeout);
    assign w_sel_acc     = w_ready_state && sel_valid && w_sel_ok && !w_cancel_acc;
    assign w_coin_acc    = w_ready_state && coin_valid && w_coin_nz && w_sum_ok
                           && !w_cancel_acc && !w_sel_acc;
    assign w_chg_fire    = w_chg_valid && change_ready;

`ifdef VEND_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_to_w-1:0] r_idle_cnt;
    logic              w_idle;

    assign w_idle    = (r_state == ST_CREDIT) && !coin_valid && !sel_valid && !cancel;
    assign w_timeout = w_idle && (r_idle_cnt == c_to_w'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_idle || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_to_w'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_chg_load        = 1'b0;
        w_dispense_nxt    = '0;
        w_coin_reject_nxt = coin_valid && w_coin_nz && !w_coin_acc;
        w_sel_nack_nxt    = sel_valid && !w_sel_acc;
        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                if (w_cancel_acc) begin
                    w_state_nxt = ST_CHANGE;
                    w_chg_load  = 1'b1;
                end else if (w_sel_acc) begin
                    w_state_nxt    = ST_DISPENSE;
                    w_credit_nxt   = r_credit - w_price;
                    w_dispense_nxt = NUM_PROD'(1) << sel_id;
                end else if (w_coin_acc) begin
                    w_state_nxt  = ST_CREDIT;
                    w_credit_nxt = w_sum[CREDIT_W-1:0];
                end
            end
            ST_DISPENSE: begin
                if (r_credit != '0) begin
                    w_state_nxt = ST_CHANGE;
                    w_chg_load  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (w_chg_fire) begin
                    w_credit_nxt = r_credit - w_chg_amt;
                    if (w_chg_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    assign w_green_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CREDIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_coin_reject <= 1'b0;
            r_sel_nack    <= 1'b0;
            r_dispense    <= '0;
            r_led_green   <= 1'b0;
            r_led_yellow  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_sel_nack    <= w_sel_nack_nxt;
            r_dispense    <= w_dispense_nxt;
            r_led_green   <= w_green_nxt;
            r_led_yellow  <= !w_green_nxt;
        end
    end

    vend_change_out #(
        .CREDIT_W    (CREDIT_W),
        .CHANGE_UNIT (CHANGE_UNIT)
    ) u_change_out (
        .clk          (clk),
        .rst          (rst),
        .load         (w_chg_load),
        .load_val     (r_credit),
        .change_ready (change_ready),
        .change_valid (w_chg_valid),
        .change_amt   (w_chg_amt),
        .last         (w_chg_last)
    );

    assign credit       = r_credit;
    assign coin_reject  = r_coin_reject;
    assign sel_nack     = r_sel_nack;
    assign dispencer    = r_dispense;
    assign change_valid = w_chg_valid;
    assign change_amt   = w_chg_amt;
    assign LED_Green    = r_led_green;
    assign LED_Yellow   = r_led_yellow;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_ctrl_multi
// Description : Directed, table-driven self-checking bench for vend_ctrl_multi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       change_ready;

    logic [7:0] credit, change_amt;
    logic       coin_reject, sel_nack, change_valid, LED_Green, LED_Yellow;
    logic [3:0] dispencer;

    logic [7:0] credit2, change_amt2;
    logic       coin_reject2, sel_nack2, change_valid2, LED_Green2, LED_Yellow2;
    logic [2:0] dispencer2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vend_ctrl_multi #(
        .TIMEOUT_CYC (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .cancel       (cancel),
        .change_ready (change_ready),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .sel_nack     (sel_nack),
        .dispencer    (dispencer),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .LED_Green    (LED_Green),
        .LED_Yellow   (LED_Yellow)
    );

    vend_ctrl_multi #(
        .NUM_PROD    (3),
        .PRICE_TABLE ({8'd20, 8'd15, 8'd10}),
        .TIMEOUT_CYC (16)
    ) dut3 (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .cancel       (cancel),
        .change_ready (change_ready),
        .credit       (credit2),
        .coin_reject  (coin_reject2),
        .sel_nack     (sel_nack2),
        .dispencer    (dispencer2),
        .change_valid (change_valid2),
        .change_amt   (change_amt2),
        .LED_Green    (LED_Green2),
        .LED_Yellow   (LED_Yellow2)
    );

    typedef struct {
        logic       cv;
        logic [3:0] coin;
        logic       sv;
        logic [1:0] sid;
        logic       can;
        logic       rdy;
        logic [7:0] e_credit;
        logic       e_rej;
        logic       e_nack;
        logic [3:0] e_disp;
        logic       e_chv;
        logic [7:0] e_amt;
        logic       e_g;
        logic       e_y;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cv, input int cn, input int sv, input int sid,
                                input int can, input int rdy, input int cr, input int rej,
                                input int nack, input int disp, input int chv, input int amt,
                                input int g, input int y);
        vec_t v;
        v.cv = 1'(cv);   v.coin = 4'(cn);  v.sv = 1'(sv);       v.sid = 2'(sid);
        v.can = 1'(can); v.rdy = 1'(rdy);  v.e_credit = 8'(cr); v.e_rej = 1'(rej);
        v.e_nack = 1'(nack); v.e_disp = 4'(disp); v.e_chv = 1'(chv);
        v.e_amt = 8'(amt);   v.e_g = 1'(g);       v.e_y = 1'(y);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_in();
        coin_valid   = 1'b0;
        coin         = 4'd0;
        sel_valid    = 1'b0;
        sel_id       = 2'd0;
        cancel       = 1'b0;
        change_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit done;
        int hs;

        // cv coin sv sid can rdy | credit rej nack disp chv amt g y
        vecs.push_back(mk(1, 5, 0,0, 0,1,   5, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(1, 5, 0,0, 0,1,  10, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(0, 0, 1,3, 0,1,   5, 0,0, 8, 0,0, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,1,   5, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,1,   0, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(1,10, 0,0, 0,1,  10, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(1,10, 0,0, 0,1,  20, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(0, 0, 1,1, 0,1,   5, 0,0, 2, 0,0, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,1,   5, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,1,   0, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(1,10, 0,0, 0,1,  10, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(0, 0, 1,2, 0,1,  10, 0,1, 0, 0,0, 1,0));
        vecs.push_back(mk(0, 0, 0,0, 0,1,  10, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(1,10, 0,0, 0,1,  20, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(0, 0, 0,0, 1,0,  20, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,0,  20, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,0,  20, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,0,  20, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,1,  15, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,1,  10, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,1,   5, 0,0, 0, 1,5, 0,1));
        vecs.push_back(mk(0, 0, 0,0, 0,1,   0, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(1,10, 0,0, 0,1,  10, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(1, 5, 1,0, 0,1,   0, 1,0, 1, 0,0, 0,1));
        vecs.push_back(mk(1, 5, 1,0, 0,1,   0, 1,1, 0, 0,0, 1,0));
        vecs.push_back(mk(0, 0, 0,0, 0,1,   0, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(1, 0, 0,0, 0,1,   0, 0,0, 0, 0,0, 1,0));
        vecs.push_back(mk(0, 0, 0,0, 1,1,   0, 0,0, 0, 0,0, 1,0));

        idle_in();
        rst = 1'b1;
        step();
        step();
        chk("rst_credit", 32'(credit), 0);
        chk("rst_outputs", 32'({coin_reject, sel_nack, dispencer, change_valid, LED_Green, LED_Yellow}), 0);
        chk("rst_amt", 32'(change_amt), 0);
        rst = 1'b0;
        step();
        chk("post_rst_green", 32'(LED_Green), 1);
        chk("post_rst_yellow", 32'(LED_Yellow), 0);

        foreach (vecs[i]) begin
            coin_valid   = vecs[i].cv;
            coin         = vecs[i].coin;
            sel_valid    = vecs[i].sv;
            sel_id       = vecs[i].sid;
            cancel       = vecs[i].can;
            change_ready = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_credit", i), 32'(credit), 32'(vecs[i].e_credit));
            chk($sformatf("v%0d_reject", i), 32'(coin_reject), 32'(vecs[i].e_rej));
            chk($sformatf("v%0d_nack", i), 32'(sel_nack), 32'(vecs[i].e_nack));
            chk($sformatf("v%0d_disp", i), 32'(dispencer), 32'(vecs[i].e_disp));
            chk($sformatf("v%0d_chv", i), 32'(change_valid), 32'(vecs[i].e_chv));
            chk($sformatf("v%0d_amt", i), 32'(change_amt), 32'(vecs[i].e_amt));
            chk($sformatf("v%0d_green", i), 32'(LED_Green), 32'(vecs[i].e_g));
            chk($sformatf("v%0d_yellow", i), 32'(LED_Yellow), 32'(vecs[i].e_y));
        end
        idle_in();

        // Credit saturation boundary, then a long chunked refund.
        for (int i = 0; i < 25; i++) begin
            coin_valid = 1'b1;
            coin       = 4'd10;
            step();
        end
        chk("sat_250", 32'(credit), 250);
        step();
        chk("sat_over_reject", 32'(coin_reject), 1);
        chk("sat_over_credit", 32'(credit), 250);
        coin = 4'd5;
        step();
        chk("sat_max_reject", 32'(coin_reject), 0);
        chk("sat_max_credit", 32'(credit), 255);
        coin = 4'd1;
        step();
        chk("sat_full_reject", 32'(coin_reject), 1);
        chk("sat_full_credit", 32'(credit), 255);
        idle_in();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("big_refund_amt", 32'(change_amt), 5);
        chk("big_refund_credit", 32'(credit), 255);
        hs   = 0;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (change_valid) begin
                hs++;
                step();
            end else begin
                done = 1'b1;
            end
        end
        chk("big_refund_done", 32'(change_valid), 0);
        chk("big_refund_chunks", 32'(hs), 51);
        chk("big_refund_credit0", 32'(credit), 0);
        chk("big_refund_green", 32'(LED_Green), 1);

        // Reset while change is pending.
        coin_valid = 1'b1;
        coin       = 4'd10;
        step();
        idle_in();
        cancel       = 1'b1;
        change_ready = 1'b0;
        step();
        cancel = 1'b0;
        chk("pre_rst_chv", 32'(change_valid), 1);
        rst = 1'b1;
        step();
        chk("rst_chg_credit", 32'(credit), 0);
        chk("rst_chg_outputs", 32'({coin_reject, sel_nack, dispencer, change_valid, LED_Green, LED_Yellow}), 0);
        rst = 1'b0;
        change_ready = 1'b1;
        step();
        chk("rst_chg_recover_green", 32'(LED_Green), 1);
        chk("rst_chg_recover_chv", 32'(change_valid), 0);

        // Out-of-range id on the three-product build vs in-range on the default build.
        coin_valid = 1'b1;
        coin       = 4'd5;
        step();
        idle_in();
        chk("np3_credit", 32'(credit2), 5);
        sel_valid = 1'b1;
        sel_id    = 2'd3;
        step();
        idle_in();
        chk("np3_nack", 32'(sel_nack2), 1);
        chk("np3_no_disp", 32'(dispencer2), 0);
        chk("np3_credit_kept", 32'(credit2), 5);
        chk("np4_disp", 32'(dispencer), 8);
        step();
        chk("np3_nack_pulse", 32'(sel_nack2), 0);
        chk("np4_disp_pulse", 32'(dispencer), 0);

`ifdef VEND_TIMEOUT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        coin_valid = 1'b1;
        coin       = 4'd10;
        step();
        idle_in();
        repeat (15) step();
        chk("to_not_yet_chv", 32'(change_valid), 0);
        chk("to_not_yet_credit", 32'(credit), 10);
        step();
        chk("to_fire_chv", 32'(change_valid), 1);
        chk("to_fire_amt", 32'(change_amt), 5);
        step();
        chk("to_first_credit", 32'(credit), 5);
        chk("to_first_chv", 32'(change_valid), 1);
        step();
        chk("to_done_chv", 32'(change_valid), 0);
        chk("to_done_credit", 32'(credit), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
